// File: rtl/gray_step_monitor.sv
// gray_step_monitor
// Accepts Gray-coded samples on a valid/ready stream. Each sample is converted
// to binary and classified against the previous one: still, up, down or an
// illegal step. The result sits in a one-entry output register. A small FSM
// tracks lock. It declares loss of lock after LOSS_LIM consecutive illegal steps.
// It re-seeds on the next sample.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. s_ready = ~m_valid | m_ready, so the output register can refill in the
// same cycle it drains. There is no combinational path from s_valid to m_valid.
module gray_step_monitor #(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16,
  parameter int LOSS_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_gray,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_bin,
  output logic [1:0]        m_dir,
  output logic              m_err,
  output logic              locked,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              clr_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_TRACK = 2'd1,
    ST_LOST  = 2'd2
  } state_t;

  localparam int RUN_W = (LOSS_LIM < 2) ? 1 : $clog2(LOSS_LIM + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(LOSS_LIM - 1);
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [RUN_W-1:0]    r_run;
  logic [RUN_W-1:0]    w_run_nxt;
  logic [DATA_W-1:0]   r_prev;
  logic                r_valid;
  logic [DATA_W-1:0]   r_bin;
  logic [1:0]          r_dir;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;

  logic [DATA_W-1:0]   w_bin;
  logic [DATA_W-1:0]   w_delta;
  logic [1:0]          w_dir;
  logic                w_err;
  logic                w_in_xfer;
  logic                w_out_xfer;

  assign s_ready    = ~r_valid | m_ready;
  assign w_in_xfer  = s_valid & s_ready;
  assign w_out_xfer = r_valid & m_ready;
  assign w_delta    = w_bin - r_prev;

  // Gray to binary: each binary bit is the XOR of the bit above it with the Gray bit.
  always_comb begin
    logic [DATA_W-1:0] v_bin;
    v_bin = '0;
    v_bin[DATA_W-1] = s_gray[DATA_W-1];
    for (int i = DATA_W - 2; i >= 0; i--) begin
      v_bin[i] = v_bin[i+1] ^ s_gray[i];
    end
    w_bin = v_bin;
  end

  // Step classification. A seeding sample (FIRST/LOST) is always "still" with no error.
  always_comb begin
    w_dir = 2'b00;
    w_err = 1'b0;
    if (r_state == ST_TRACK) begin
      if (w_delta == '0) begin
        w_dir = 2'b00;
      end else if (w_delta == ONE) begin
        w_dir = 2'b01;
      end else if (w_delta == '1) begin
        w_dir = 2'b10;
      end else begin
        w_dir = 2'b11;
        w_err = 1'b1;
      end
    end
  end

  // Lock FSM next state and the consecutive illegal-step run. It advances only on input transfers.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    if (w_in_xfer) begin
      case (r_state)
        ST_FIRST, ST_LOST: begin
          w_state_nxt = ST_TRACK;
          w_run_nxt   = '0;
        end
        ST_TRACK: begin
          if (w_err) begin
            w_run_nxt = r_run + RUN_W'(1);
            if (r_run == RUN_LAST) begin
              w_state_nxt = ST_LOST;
            end
          end else begin
            w_run_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = ST_FIRST;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state, run counter and previous binary value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FIRST;
      r_run   <= '0;
      r_prev  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      if (w_in_xfer) begin
        r_prev <= w_bin;
      end
    end
  end

  // One-entry output register. A new sample overwrites it only while it drains or is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_bin   <= '0;
      r_dir   <= 2'b00;
      r_err   <= 1'b0;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_bin   <= w_bin;
      r_dir   <= w_dir;
      r_err   <= w_err;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating total of illegal steps. clr_cnt wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_in_xfer && w_err && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign m_valid   = r_valid;
  assign m_bin     = r_bin;
  assign m_dir     = r_dir;
  assign m_err     = r_err;
  assign locked    = (r_state == ST_TRACK);
  assign err_cnt   = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Testbench for gray_step_monitor. Two instances share one stimulus stream:
// one uses the default 16-bit error counter, and one uses a 2-bit counter to
// exercise saturation. A reference model at the sample level predicts each result.
module tb_gray_step_monitor;

  localparam int DATA_W   = 8;
  localparam int CNT_W    = 16;
  localparam int CNT_W2   = 2;
  localparam int LOSS_LIM = 3;
  localparam int EW       = DATA_W + 3;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;
  localparam int unsigned CNT_MAX2 = (1 << CNT_W2) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_gray = '0;
  logic              m_ready = 1'b1;
  logic              clr_cnt = 1'b0;

  logic              s_ready, m_valid, m_err, locked;
  logic [DATA_W-1:0] m_bin;
  logic [1:0]        m_dir, dbg_state;
  logic [CNT_W-1:0]  err_cnt;

  logic              s_ready_c, m_valid_c, m_err_c, locked_c;
  logic [DATA_W-1:0] m_bin_c;
  logic [1:0]        m_dir_c, dbg_state_c;
  logic [CNT_W2-1:0] err_cnt_c;

  gray_step_monitor #(.DATA_W(DATA_W), .CNT_W(CNT_W), .LOSS_LIM(LOSS_LIM)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_gray(s_gray),
    .m_valid(m_valid), .m_ready(m_ready), .m_bin(m_bin), .m_dir(m_dir),
    .m_err(m_err), .locked(locked), .err_cnt(err_cnt), .clr_cnt(clr_cnt),
    .dbg_state(dbg_state)
  );

  gray_step_monitor #(.DATA_W(DATA_W), .CNT_W(CNT_W2), .LOSS_LIM(LOSS_LIM)) dut_c (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_c), .s_gray(s_gray),
    .m_valid(m_valid_c), .m_ready(m_ready), .m_bin(m_bin_c), .m_dir(m_dir_c),
    .m_err(m_err_c), .locked(locked_c), .err_cnt(err_cnt_c), .clr_cnt(clr_cnt),
    .dbg_state(dbg_state_c)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                seed  = 1'b1;
  int                run   = 0;
  logic [DATA_W-1:0] mprev = '0;
  bit                mv    = 1'b0;
  int unsigned       cnt   = 0;
  int unsigned       cnt2  = 0;

  function automatic logic [DATA_W-1:0] g2b(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int k = 0; k < DATA_W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic model_step();
    logic acc;
    logic [DATA_W-1:0] b, d;
    logic [1:0] dir;
    logic err;
    if (rst) begin
      mv = 0; seed = 1; run = 0; mprev = '0; cnt = 0; cnt2 = 0;
      exp_q.delete();
    end else begin
      acc = s_valid && (!mv || m_ready);
      if (acc) begin
        b = g2b(s_gray);
        dir = 2'b00;
        err = 1'b0;
        if (seed) begin
          seed = 0;
          run = 0;
        end else begin
          d = b - mprev;
          if (d == 0) dir = 2'b00;
          else if (d == 1) dir = 2'b01;
          else if (d == {DATA_W{1'b1}}) dir = 2'b10;
          else begin dir = 2'b11; err = 1'b1; end
          if (err) begin
            run++;
            if (run >= LOSS_LIM) begin seed = 1; run = 0; end
          end else begin
            run = 0;
          end
        end
        if (err && cnt < CNT_MAX) cnt++;
        if (err && cnt2 < CNT_MAX2) cnt2++;
        mprev = b;
        exp_q.push_back({b, dir, err});
        mv = 1;
      end else if (m_ready) begin
        mv = 0;
      end
      if (clr_cnt) begin cnt = 0; cnt2 = 0; end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor ----------------
  initial forever begin
    logic [EW-1:0] e;
    @(negedge clk);
    chk("m_valid", m_valid, mv);
    chk("m_valid_c", m_valid_c, mv);
    chk("s_ready", s_ready, (!mv || m_ready));
    chk("s_ready_c", s_ready_c, (!mv || m_ready));
    chk("locked", locked, !seed);
    chk("locked_c", locked_c, !seed);
    chk("err_cnt", err_cnt, cnt);
    chk("err_cnt_c", err_cnt_c, cnt2);
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL result: output presented with no expected entry at %0t", $time);
      end else begin
        e = exp_q[0];
        chk("result", {m_bin, m_dir, m_err}, e);
        chk("result_c", {m_bin_c, m_dir_c, m_err_c}, e);
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit rand_rdy = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic do_reset();
    s_valid = 0;
    clr_cnt = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_m_bin", m_bin, 0);
    chk("rst_m_dir", m_dir, 0);
    chk("rst_m_err", m_err, 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic send(input logic [DATA_W-1:0] g);
    int waited;
    logic rdy;
    waited = 0;
    s_valid = 1;
    s_gray = g;
    forever begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited >= 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: s_ready low for %0d cycles, gray 0x%0h", waited, g);
        break;
      end
    end
    s_valid = 0;
  endtask

  task automatic send_chk(input logic [DATA_W-1:0] g, input logic [DATA_W-1:0] eb,
                          input logic [1:0] ed);
    send(g);
    chk("dir_bin", m_bin, eb);
    chk("dir_dir", m_dir, ed);
  endtask

  task automatic idle(input int n);
    s_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [DATA_W-1:0] last_b, nb;
    int r;

    do_reset();

    // Basic stream.
    m_ready = 1;
    send_chk(8'h07, 8'd5, 2'b00);
    send_chk(8'h05, 8'd6, 2'b01);
    send_chk(8'h07, 8'd5, 2'b10);
    send_chk(8'h06, 8'd4, 2'b10);
    idle(1);
    chk("stream_locked", locked, 1);
    chk("stream_err_cnt", err_cnt, 0);

    // Wrap-around.
    do_reset();
    send_chk(8'h80, 8'd255, 2'b00);
    send_chk(8'h00, 8'd0, 2'b01);
    send_chk(8'h80, 8'd255, 2'b10);
    chk("wrap_err_cnt", err_cnt, 0);

    // One illegal step, then repeats.
    do_reset();
    send_chk(8'h00, 8'd0, 2'b00);
    send_chk(8'h0D, 8'd9, 2'b11);
    send_chk(8'h0D, 8'd9, 2'b00);
    send_chk(8'h0D, 8'd9, 2'b00);
    chk("ill1_err_cnt", err_cnt, 1);
    chk("ill1_locked", locked, 1);

    // Three illegal steps in a row lose lock; the next sample re-seeds.
    do_reset();
    send_chk(8'h00, 8'd0, 2'b00);
    send_chk(8'h0D, 8'd9, 2'b11);
    send_chk(8'h03, 8'd2, 2'b11);
    send_chk(8'h0D, 8'd9, 2'b11);
    chk("loss_locked", locked, 0);
    chk("loss_err_cnt", err_cnt, 3);
    send_chk(8'h0D, 8'd9, 2'b00);
    chk("relock_locked", locked, 1);

    // Backpressure: the output holds while m_ready is low.
    do_reset();
    m_ready = 0;
    send(8'h10);
    s_valid = 1;
    s_gray = 8'h30;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_m_bin", m_bin, 8'h1F);
      @(posedge clk);
      #1;
    end
    m_ready = 1;
    send(8'h30);
    chk("bp_next_bin", m_bin, 8'h20);
    chk("bp_next_dir", m_dir, 2'b01);
    idle(2);

    // Counter saturation on the narrow counter, then clear over an illegal step.
    do_reset();
    send(8'h00);
    send(8'h0D);
    send(8'h03);
    send(8'h0D);
    send(8'h0D);
    send(8'h03);
    chk("sat_err_cnt_c", err_cnt_c, 3);
    chk("sat_err_cnt", err_cnt, 4);
    clr_cnt = 1;
    send(8'h0D);
    clr_cnt = 0;
    chk("clr_err_cnt_c", err_cnt_c, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_m_err", m_err, 1);

    // Reset mid-stream with a pending result.
    do_reset();
    m_ready = 0;
    send(8'h07);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("midrst_m_valid", m_valid, 0);
    m_ready = 1;
    send_chk(8'h05, 8'd6, 2'b00);
    idle(1);

    // Randomized phase: mostly legal steps, with random backpressure, clears and resets.
    do_reset();
    rand_rdy = 1;
    last_b = '0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) nb = last_b;
      else if (r <= 5) nb = last_b + 8'd1;
      else if (r <= 8) nb = last_b - 8'd1;
      else nb = 8'($urandom_range(0, 255));
      last_b = nb;
      clr_cnt = ($urandom_range(0, 19) == 0);
      send(nb ^ (nb >> 1));
      clr_cnt = 0;
      if ($urandom_range(0, 59) == 0) begin
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
      end
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    // Drain.
    rand_rdy = 0;
    #0;
    m_ready = 1;
    idle(5);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
